// File: rtl/gf180mcu_osu_sc_gp9t3v3__arb_pkg.sv
// Shared types and constants for the 2:1 mux select arbiter.
// Holds the arbiter state encoding, the mux select encodings and small helpers.
package gf180mcu_osu_sc_gp9t3v3__arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SWITCH  = 2'b01,
        ST_GRANT_A = 2'b10,
        ST_GRANT_B = 2'b11
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Grant state that matches a given mux select value.
    function automatic arb_state_e grant_state(input logic side);
        return side ? ST_GRANT_B : ST_GRANT_A;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__dwellcnt.sv
// Saturating dwell counter with synchronous clear and enable.
// Times both the dead interval after a select change and the grant hold interval.
module gf180mcu_osu_sc_gp9t3v3__dwellcnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__mux2arb_1.sv
// Round-robin select controller for a downstream 2:1 mux cell.
// Holds SEL stable during a grant and forces dead cycles (both grants low) on every SEL change.
module gf180mcu_osu_sc_gp9t3v3__mux2arb_1
    import gf180mcu_osu_sc_gp9t3v3__arb_pkg::*;
#(
    parameter int HOLD_MIN = 2,
    parameter int DEAD     = 1,
    parameter int CNT_W    = 4
) (
    input  logic CLK,
    input  logic R,
    input  logic REQA,
    input  logic REQB,
    input  logic DONE,
    output logic SEL,
    output logic GNTA,
    output logic GNTB,
    output logic BUSY
);

    localparam int HOLD_EFF = (HOLD_MIN < 1) ? 1 : HOLD_MIN;
    localparam int CNT_MAX  = (2 ** CNT_W) - 1;

    if (DEAD < 1) begin : g_bad_dead
        $error("DEAD must be at least 1");
    end
    if (CNT_MAX < max_int(HOLD_MIN, DEAD)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for HOLD_MIN/DEAD");
    end

    localparam logic [CNT_W:0] HOLD_LIM = (CNT_W+1)'(HOLD_EFF);
    localparam logic [CNT_W:0] DEAD_LIM = (CNT_W+1)'(DEAD);

    arb_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             gnta_q, gnta_d;
    logic             gntb_q, gntb_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             cnt_clr;
    logic             cnt_en;
    logic             win;
    logic             side;
    logic             mine_req;
    logic             other_req;

    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

    // Next-state, select and round-robin pointer logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        win       = 1'b0;
        side      = state_q[0];
        mine_req  = state_q[0] ? REQB : REQA;
        other_req = state_q[0] ? REQA : REQB;
        case (state_q)
            ST_IDLE: begin
                if (REQA || REQB) begin
                    if (REQA && REQB) begin
                        win = ~last_q;
                    end else begin
                        win = REQB ? SEL_B : SEL_A;
                    end
                    if (win == sel_q) begin
                        state_d = grant_state(win);
                    end else begin
                        sel_d   = win;
                        state_d = ST_SWITCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                // Requests are only rechecked for the side the mux now points at.
                if (cnt_inc >= DEAD_LIM) begin
                    if ((sel_q == SEL_B) ? REQB : REQA) begin
                        state_d = grant_state(sel_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SWITCH;
                end
            end
            ST_GRANT_A, ST_GRANT_B: begin
                if ((DONE && (cnt_inc >= HOLD_LIM)) || !mine_req) begin
                    last_d = side;
                    if (other_req) begin
                        sel_d   = ~side;
                        state_d = ST_SWITCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter restarts on every state change so it measures time spent in the current state.
    always_comb begin
        cnt_clr = (state_d != state_q) || (state_q == ST_IDLE);
        cnt_en  = (state_q != ST_IDLE);
        gnta_d  = (state_d == ST_GRANT_A);
        gntb_d  = (state_d == ST_GRANT_B);
        busy_d  = (state_d != ST_IDLE);
    end

    gf180mcu_osu_sc_gp9t3v3__dwellcnt #(
        .CNT_W (CNT_W)
    ) u_dwellcnt (
        .clk (CLK),
        .r   (R),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt)
    );

    // State and output registers; reset leaves last=B so A wins the first tie.
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_A;
            last_q  <= SEL_B;
            gnta_q  <= 1'b0;
            gntb_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnta_q  <= gnta_d;
            gntb_q  <= gntb_d;
            busy_q  <= busy_d;
        end
    end

    assign SEL  = sel_q;
    assign GNTA = gnta_q;
    assign GNTB = gntb_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__mux2arb_1.sv
// Bench for the mux select arbiter: directed vector table, hand sequences for long
// dead/hold intervals, and randomized traffic against a behavioural model on two configurations.
module tb_gf180mcu_osu_sc_gp9t3v3__mux2arb_1;

    typedef struct {
        logic [3:0] stim;  // {R, REQA, REQB, DONE}
        logic [3:0] exp;   // {SEL, GNTA, GNTB, BUSY}
    } vec_t;

    logic clk = 1'b0;
    logic r = 1'b1, reqa = 1'b0, reqb = 1'b0, done = 1'b0;
    logic sel0, gnta0, gntb0, busy0;
    logic sel1, gnta1, gntb1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode 0 idle, 1 dead interval, 2 granted; side = mux position.
    int hold_p[2]  = '{2, 15};
    int dead_p[2]  = '{1, 3};
    int mode[2]    = '{0, 0};
    int side[2]    = '{0, 0};
    int prev[2]    = '{1, 1};
    int elapsed[2] = '{0, 0};

    vec_t tbl[$];

    always #5 clk = ~clk;

    gf180mcu_osu_sc_gp9t3v3__mux2arb_1 #(.HOLD_MIN(2), .DEAD(1), .CNT_W(4)) dut0 (
        .CLK(clk), .R(r), .REQA(reqa), .REQB(reqb), .DONE(done),
        .SEL(sel0), .GNTA(gnta0), .GNTB(gntb0), .BUSY(busy0)
    );

    gf180mcu_osu_sc_gp9t3v3__mux2arb_1 #(.HOLD_MIN(15), .DEAD(3), .CNT_W(4)) dut1 (
        .CLK(clk), .R(r), .REQA(reqa), .REQB(reqb), .DONE(done),
        .SEL(sel1), .GNTA(gnta1), .GNTB(gntb1), .BUSY(busy1)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int req_side;
            int w;
            if (r) begin
                mode[i] = 0; side[i] = 0; prev[i] = 1; elapsed[i] = 0;
            end else if (mode[i] == 0) begin
                if (reqa || reqb) begin
                    w = (reqa && reqb) ? 1 - prev[i] : (reqb ? 1 : 0);
                    if (w != side[i]) begin
                        side[i] = w;
                        mode[i] = 1;
                    end else begin
                        mode[i] = 2;
                    end
                    elapsed[i] = 0;
                end
            end else if (mode[i] == 1) begin
                elapsed[i]++;
                if (elapsed[i] >= dead_p[i]) begin
                    req_side   = (side[i] == 1) ? int'(reqb) : int'(reqa);
                    mode[i]    = (req_side != 0) ? 2 : 0;
                    elapsed[i] = 0;
                end
            end else begin
                elapsed[i]++;
                req_side = (side[i] == 1) ? int'(reqb) : int'(reqa);
                if ((done && elapsed[i] >= hold_p[i]) || req_side == 0) begin
                    prev[i] = side[i];
                    if (((side[i] == 1) ? reqa : reqb) == 1'b1) begin
                        side[i]    = 1 - side[i];
                        mode[i]    = 1;
                        elapsed[i] = 0;
                    end else begin
                        mode[i] = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {SEL,GNTA,GNTB,BUSY}=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_out(input int i);
        logic [3:0] o;
        o[3] = (side[i] == 1);
        o[2] = (mode[i] == 2) && (side[i] == 0);
        o[1] = (mode[i] == 2) && (side[i] == 1);
        o[0] = (mode[i] != 0);
        return o;
    endfunction

    task automatic step(input logic [3:0] s);
        {r, reqa, reqb, done} = s;
        @(negedge clk);
    endtask

    task automatic add(input logic [3:0] s, input logic [3:0] e);
        vec_t v;
        v.stim = s;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    initial begin
        // Directed sequence: reset, tie, alternation, abandon, reset mid-switch, back-to-back, B path.
        add(4'b1110, 4'b0000); add(4'b1110, 4'b0000); add(4'b0110, 4'b0101);
        add(4'b0111, 4'b0101); add(4'b0111, 4'b1001); add(4'b0111, 4'b1011);
        add(4'b0111, 4'b1011); add(4'b0111, 4'b0001); add(4'b0111, 4'b0101);
        add(4'b0010, 4'b1001); add(4'b0010, 4'b1011); add(4'b0000, 4'b1000);
        add(4'b0100, 4'b0001); add(4'b0100, 4'b0101); add(4'b0010, 4'b1001);
        add(4'b1010, 4'b0000); add(4'b0100, 4'b0101); add(4'b0101, 4'b0101);
        add(4'b0101, 4'b0000); add(4'b0100, 4'b0101); add(4'b0000, 4'b0000);
        add(4'b0010, 4'b1001); add(4'b0010, 4'b1011); add(4'b0001, 4'b1000);
        add(4'b0001, 4'b1000);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].stim);
            check($sformatf("vec%0d", i), {sel0, gnta0, gntb0, busy0}, tbl[i].exp);
            if (i >= 1) begin
                check($sformatf("vec%0d_d1", i), {sel1, gnta1, gntb1, busy1}, model_out(1));
            end
        end

        // DEAD=3, HOLD_MIN=15 on dut1: grant after 3 dead cycles, release after exactly 15 granted cycles.
        step(4'b1000);
        check("hs_reset", {sel1, gnta1, gntb1, busy1}, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step(4'b0010);
            check($sformatf("hs_dead%0d", k), {sel1, gnta1, gntb1, busy1}, 4'b1001);
        end
        step(4'b0010);
        check("hs_grant", {sel1, gnta1, gntb1, busy1}, 4'b1011);
        for (int k = 0; k < 14; k++) begin
            step(4'b0011);
            check($sformatf("hs_hold%0d", k), {sel1, gnta1, gntb1, busy1}, 4'b1011);
        end
        step(4'b0011);
        check("hs_release", {sel1, gnta1, gntb1, busy1}, 4'b1000);

        // Randomized traffic on both configurations against the model.
        step(4'b1000);
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] s;
            s[3] = ($urandom_range(0, 99) == 0);
            s[2] = ($urandom_range(0, 3) != 0) ? reqa : logic'($urandom_range(0, 1));
            s[1] = ($urandom_range(0, 3) != 0) ? reqb : logic'($urandom_range(0, 1));
            s[0] = ($urandom_range(0, 2) == 0);
            step(s);
            check("rnd_d0", {sel0, gnta0, gntb0, busy0}, model_out(0));
            check("rnd_d1", {sel1, gnta1, gntb1, busy1}, model_out(1));
            if ((gnta0 && gntb0) || (gnta1 && gntb1)) begin
                n_checks++;
                n_errors++;
                $display("FAIL excl: both grants high, d0=%b%b d1=%b%b", gnta0, gntb0, gnta1, gntb1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
